// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared state encoding and default width for the sequential divider.
package seq_div_pkg;
    localparam int DEF_W = 4;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/seq_div_step.sv
// seq_div_step: one restoring-division step, shifting the next dividend bit into the partial remainder.
module seq_div_step #(
    parameter int W = 4
) (
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);
    logic [W:0] t;
    logic [W:0] diff;
    assign t     = {rem_i, bit_i};
    assign diff  = t - {1'b0, divisor_i};
    assign q_o   = t >= {1'b0, divisor_i};
    assign rem_o = q_o ? diff[W-1:0] : t[W-1:0];
endmodule

// File: rtl/seq_div.sv
// seq_div: multi-cycle unsigned restoring divider, one quotient bit per clock with start/done handshake.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero
);
    localparam int CW = $clog2(2*W);
    localparam logic [CW-1:0] LAST = CW'(2*W-1);
    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic [2*W-1:0] work_q, work_d, quotient_q;
    logic [W-1:0]   rem_q, rem_d, dvs_q, remainder_q;
    logic           done_q, dbz_q, qbit;
    seq_div_step #(.W(W)) u_step (
        .rem_i    (rem_q),
        .bit_i    (work_q[2*W-1]),
        .divisor_i(dvs_q),
        .rem_o    (rem_d),
        .q_o      (qbit)
    );
    // Quotient bits refill the dividend register from the bottom as dividend bits leave the top.
    assign work_d = {work_q[2*W-2:0], qbit};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == RUN) begin
                work_q <= work_d;
                rem_q  <= rem_d;
                cnt_q  <= cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_q     <= DONE;
                    cnt_q       <= '0;
                    done_q      <= 1'b1;
                    quotient_q  <= work_d;
                    remainder_q <= rem_d;
                end
            end else if (start && divisor != '0) begin
                state_q <= RUN;
                work_q  <= dividend;
                dvs_q   <= divisor;
                rem_q   <= '0;
                cnt_q   <= '0;
                dbz_q   <= 1'b0;
            end else if (start) begin
                state_q     <= DONE;
                done_q      <= 1'b1;
                quotient_q  <= '1;
                remainder_q <= dividend[W-1:0];
                dbz_q       <= 1'b1;
            end else begin
                state_q <= IDLE;
            end
        end
    end
    assign busy        = state_q == RUN;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
endmodule
